// File: rtl/multi_acc_calculator_if.sv
// Command/result bundle between the calculator front-end (master) and multi_acc_calculator (slave).
interface multi_acc_calculator_if #(
  parameter int DATA_WIDTH    = 10,
  parameter int RESULT_WIDTH  = 18,
  parameter int ACC_SEL_WIDTH = 2
);
  logic                     CLEAR;
  logic                     COMPUTE;
  logic [2:0]               OPERATION;
  logic [ACC_SEL_WIDTH-1:0] ACC_SEL;
  logic [DATA_WIDTH-1:0]    CALC_DATA;
  logic                     BUSY;
  logic                     DONE;
  logic                     RESULT_READY;
  logic [ACC_SEL_WIDTH-1:0] RESULT_SEL;
  logic [RESULT_WIDTH-1:0]  RESULT_DATA;
  logic                     CARRY;
  logic                     OVERFLOW;
  logic                     ZERO;

  modport master (
    output CLEAR, COMPUTE, OPERATION, ACC_SEL, CALC_DATA,
    input  BUSY, DONE, RESULT_READY, RESULT_SEL, RESULT_DATA, CARRY, OVERFLOW, ZERO
  );

  modport slave (
    input  CLEAR, COMPUTE, OPERATION, ACC_SEL, CALC_DATA,
    output BUSY, DONE, RESULT_READY, RESULT_SEL, RESULT_DATA, CARRY, OVERFLOW, ZERO
  );
endinterface

// File: rtl/multi_acc_calculator.sv
// NUM_ACC accumulators sharing one ripple adder, sequenced by an IDLE/SETUP/EXEC/CLR/FIN FSM.
// Define CALC_SATURATE_EN to clamp out-of-range ADD/SUB results instead of wrapping.
module multi_acc_calculator #(
  parameter int DATA_WIDTH    = 10,
  parameter int RESULT_WIDTH  = 18,
  parameter int NUM_ACC       = 4,
  parameter int ACC_SEL_WIDTH = 2,
  parameter int SIGN_EXTEND   = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  multi_acc_calculator_if.slave  bus
);

  localparam int MSB = RESULT_WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EXEC, S_CLR, S_FIN} state_t;

  state_t                   r_state;
  logic [RESULT_WIDTH-1:0]  r_acc [NUM_ACC];
  logic [ACC_SEL_WIDTH-1:0] r_sel;
  logic [2:0]               r_op;
  logic [RESULT_WIDTH-1:0]  r_ext;
  logic [RESULT_WIDTH-1:0]  r_b;
  logic                     r_cin;
  logic                     r_busy, r_done, r_ready, r_carry, r_ovf, r_zero;

  logic [RESULT_WIDTH-1:0]  w_ext, w_a, w_sum, w_wr_val;
  logic                     w_cout, w_raw_ovf, w_wr_carry, w_wr_ovf;

  generate
    if (RESULT_WIDTH > DATA_WIDTH) begin : g_widen
      assign w_ext = {{(RESULT_WIDTH-DATA_WIDTH){(SIGN_EXTEND != 0) && bus.CALC_DATA[DATA_WIDTH-1]}},
                      bus.CALC_DATA};
    end else begin : g_same
      assign w_ext = bus.CALC_DATA;
    end
  endgenerate

  assign w_a = r_acc[r_sel];

  // NOTE: blocking assignments are correct here: the carry must ripple bit by bit within one evaluation.
  always_comb begin : ripple_adder
    logic c;
    c     = r_cin;
    w_sum = '0;
    for (int i = 0; i < RESULT_WIDTH; i++) begin
      w_sum[i] = w_a[i] ^ r_b[i] ^ c;
      c        = (w_a[i] & r_b[i]) | (c & (w_a[i] ^ r_b[i]));
    end
    w_cout = c;
  end

  // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_raw_ovf  = (w_a[MSB] == r_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
    w_wr_val   = w_a;
    w_wr_carry = 1'b0;
    w_wr_ovf   = 1'b0;
    case (r_op)
      OP_ADD:  begin w_wr_val = w_sum; w_wr_carry = w_cout;  w_wr_ovf = w_raw_ovf; end
      OP_SUB:  begin w_wr_val = w_sum; w_wr_carry = ~w_cout; w_wr_ovf = w_raw_ovf; end
      OP_AND:  w_wr_val = w_a & r_ext;
      OP_OR:   w_wr_val = w_a | r_ext;
      OP_XOR:  w_wr_val = w_a ^ r_ext;
      OP_LOAD: w_wr_val = r_ext;
      default: ;
    endcase
`ifdef CALC_SATURATE_EN
    // Flags keep the raw event; only the stored value is clamped.
    if (r_op == OP_ADD || r_op == OP_SUB) begin
      if (SIGN_EXTEND != 0) begin
        if (w_raw_ovf)
          w_wr_val = w_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end else if (w_wr_carry) begin
        w_wr_val = (r_op == OP_ADD) ? '1 : '0;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      // NOTE: the accumulators are architecturally visible after reset, so this array is reset explicitly.
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      r_sel   <= '0;
      r_op    <= OP_ADD;
      r_ext   <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.CLEAR) begin
            r_sel   <= bus.ACC_SEL;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CLR;
          end else if (bus.COMPUTE) begin
            r_sel   <= bus.ACC_SEL;
            r_op    <= bus.OPERATION;
            r_ext   <= w_ext;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_b     <= (r_op == OP_SUB) ? ~r_ext : r_ext;
          r_cin   <= (r_op == OP_SUB);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_acc[r_sel] <= w_wr_val;
          r_carry      <= w_wr_carry;
          r_ovf        <= w_wr_ovf;
          r_zero       <= (w_wr_val == '0);
          r_state      <= S_FIN;
        end
        S_CLR: begin
          r_acc[r_sel] <= '0;
          r_carry      <= 1'b0;
          r_ovf        <= 1'b0;
          r_zero       <= 1'b1;
          r_state      <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY         = r_busy;
  assign bus.DONE         = r_done;
  assign bus.RESULT_READY = r_ready;
  assign bus.RESULT_SEL   = r_sel;
  assign bus.RESULT_DATA  = w_a;
  assign bus.CARRY        = r_carry;
  assign bus.OVERFLOW     = r_ovf;
  assign bus.ZERO         = r_zero;

endmodule

// File: tb/tb_multi_acc_calculator.sv
// Testbench for multi_acc_calculator: directed plan items plus random commands against an arithmetic model.
module tb_multi_acc_calculator;

  localparam int DW = 10;
  localparam int RW = 18;
  localparam int NA = 4;
  localparam int SW = 2;
  localparam longint MOD  = 64'sd1 << RW;
  localparam longint HALF = MOD / 2;

  logic CLK = 1'b0;
  logic RESET;
  int   n_vec = 0;
  int   n_err = 0;
  longint m_acc [NA];

  multi_acc_calculator_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .ACC_SEL_WIDTH(SW)) bus ();

  multi_acc_calculator #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .NUM_ACC(NA), .ACC_SEL_WIDTH(SW), .SIGN_EXTEND(0)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Reference: unsigned values modulo 2^RW, signed view for overflow.
  task automatic model_cmd(input bit clr, input logic [2:0] op, input int sel, input logic [DW-1:0] d,
                           output logic [RW-1:0] r, output logic c, output logic v);
    longint a, e, full, sa, se, s;
    a = m_acc[sel];
    e = longint'(d);
    sa = (a >= HALF) ? a - MOD : a;
    se = (e >= HALF) ? e - MOD : e;
    c = 1'b0;
    v = 1'b0;
    full = a;
    if (clr) full = 0;
    else begin
      case (op)
        3'd0: begin
          full = a + e; c = (full >= MOD); full = full % MOD;
          s = sa + se; v = (s >= HALF) || (s < -HALF);
`ifdef CALC_SATURATE_EN
          if (c) full = MOD - 1;
`endif
        end
        3'd1: begin
          c = (e > a); full = (a - e + MOD) % MOD;
          s = sa - se; v = (s >= HALF) || (s < -HALF);
`ifdef CALC_SATURATE_EN
          if (c) full = 0;
`endif
        end
        3'd2: full = a & e;
        3'd3: full = a | e;
        3'd4: full = a ^ e;
        3'd5: full = e;
        default: full = a;
      endcase
    end
    m_acc[sel] = full;
    r = full[RW-1:0];
  endtask

  task automatic issue_and_check(input bit clr, input bit cmp, input logic [2:0] op, input int sel,
                                 input logic [DW-1:0] d, input string tag);
    logic [RW-1:0] er;
    logic ec, ev;
    int cyc, exp_lat;
    exp_lat = clr ? 3 : 4;
    model_cmd(clr, op, sel, d, er, ec, ev);
    @(negedge CLK);
    bus.CLEAR = clr; bus.COMPUTE = cmp; bus.OPERATION = op; bus.ACC_SEL = SW'(sel); bus.CALC_DATA = d;
    @(negedge CLK);
    bus.CLEAR = 1'b0; bus.COMPUTE = 1'b0;
    cyc = 1;
    n_vec++;
    if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b, expected 1", tag, bus.BUSY); end
    while (bus.DONE !== 1'b1 && cyc < 12) begin @(negedge CLK); cyc++; end
    n_vec++;
    if (cyc != exp_lat) begin n_err++; $display("FAIL %s done_latency: got %0d cycles, expected %0d", tag, cyc, exp_lat); end
    n_vec++;
    if (bus.RESULT_DATA !== er) begin n_err++; $display("FAIL %s result_data: got %h, expected %h", tag, bus.RESULT_DATA, er); end
    n_vec++;
    if (bus.RESULT_SEL !== SW'(sel)) begin n_err++; $display("FAIL %s result_sel: got %0d, expected %0d", tag, bus.RESULT_SEL, sel); end
    n_vec++;
    if (bus.CARRY !== ec) begin n_err++; $display("FAIL %s carry: got %b, expected %b", tag, bus.CARRY, ec); end
    n_vec++;
    if (bus.OVERFLOW !== ev) begin n_err++; $display("FAIL %s overflow: got %b, expected %b", tag, bus.OVERFLOW, ev); end
    n_vec++;
    if (bus.ZERO !== (er == '0)) begin n_err++; $display("FAIL %s zero: got %b, expected %b", tag, bus.ZERO, er == '0); end
    n_vec++;
    if (bus.RESULT_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      n_err++; $display("FAIL %s ready_busy: got %b/%b, expected 1/0", tag, bus.RESULT_READY, bus.BUSY);
    end
    @(negedge CLK);
    n_vec++;
    if (bus.DONE !== 1'b0 || bus.RESULT_READY !== 1'b1) begin
      n_err++; $display("FAIL %s done_pulse: got done=%b ready=%b, expected 0/1", tag, bus.DONE, bus.RESULT_READY);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RESULT_READY !== 1'b0 || bus.CARRY !== 1'b0 ||
        bus.OVERFLOW !== 1'b0 || bus.ZERO !== 1'b1 || bus.RESULT_SEL !== '0 || bus.RESULT_DATA !== '0) begin
      n_err++;
      $display("FAIL %s reset_outputs: got busy=%b done=%b rdy=%b c=%b v=%b z=%b sel=%0d data=%h, expected 0 0 0 0 0 1 0 0",
               tag, bus.BUSY, bus.DONE, bus.RESULT_READY, bus.CARRY, bus.OVERFLOW, bus.ZERO,
               bus.RESULT_SEL, bus.RESULT_DATA);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.CLEAR = 1'b0; bus.COMPUTE = 1'b0; bus.OPERATION = '0; bus.ACC_SEL = '0; bus.CALC_DATA = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RESET = 1'b0;
    for (int i = 0; i < NA; i++) m_acc[i] = 0;
  endtask

  task automatic test_directed();
    issue_and_check(0, 1, 3'd0, 0, 10'd100, "add100");
    issue_and_check(0, 1, 3'd0, 0, 10'd23,  "add23");
    n_vec++;
    if (bus.RESULT_DATA !== 18'd123) begin n_err++; $display("FAIL acc0_123: got %0d, expected 123", bus.RESULT_DATA); end
    for (int i = 1; i < NA; i++) issue_and_check(0, 1, 3'd3, i, 10'd0, "readback_zero");
    issue_and_check(0, 1, 3'd1, 1, 10'd5,     "sub5_acc1");
    issue_and_check(0, 1, 3'd5, 2, 10'h3AA,   "load_acc2");
    issue_and_check(0, 1, 3'd4, 2, 10'h0FF,   "xor_acc2");
    n_vec++;
    if (bus.RESULT_DATA !== 18'h00355) begin n_err++; $display("FAIL xor_const: got %h, expected 00355", bus.RESULT_DATA); end
    issue_and_check(0, 1, 3'd2, 2, 10'h00F,   "and_acc2");
    issue_and_check(0, 1, 3'd1, 2, 10'd5,     "sub_to_zero");
    issue_and_check(0, 1, 3'd1, 3, 10'd1,     "sub1_acc3");
    issue_and_check(0, 1, 3'd0, 3, 10'd1,     "add1_acc3");
    issue_and_check(0, 1, 3'd6, 2, 10'h3FF,   "reserved6");
    issue_and_check(0, 1, 3'd7, 0, 10'h3FF,   "reserved7");
  endtask

  task automatic test_clear_priority();
    issue_and_check(1, 1, 3'd0, 0, 10'd5, "clear_prio");
    n_vec++;
    if (bus.RESULT_DATA !== '0 || bus.ZERO !== 1'b1) begin
      n_err++; $display("FAIL clear_prio_value: got %h z=%b, expected 0 z=1", bus.RESULT_DATA, bus.ZERO);
    end
  endtask

  task automatic test_busy_ignore();
    logic [RW-1:0] er;
    logic ec, ev;
    int n_done;
    model_cmd(0, 3'd0, 2, 10'd9, er, ec, ev);
    @(negedge CLK);
    bus.COMPUTE = 1'b1; bus.OPERATION = 3'd0; bus.ACC_SEL = 2'd2; bus.CALC_DATA = 10'd9;
    @(negedge CLK);
    bus.COMPUTE = 1'b0;
    @(negedge CLK);
    bus.COMPUTE = 1'b1; bus.OPERATION = 3'd5; bus.ACC_SEL = 2'd3; bus.CALC_DATA = 10'h155;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      bus.COMPUTE = 1'b0;
      if (bus.DONE === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 1) begin n_err++; $display("FAIL busy_ignore_done_count: got %0d, expected 1", n_done); end
    n_vec++;
    if (bus.RESULT_DATA !== er || bus.RESULT_SEL !== 2'd2) begin
      n_err++; $display("FAIL busy_ignore_result: got %h sel %0d, expected %h sel 2", bus.RESULT_DATA, bus.RESULT_SEL, er);
    end
    issue_and_check(0, 1, 3'd3, 3, 10'd0, "busy_ignore_acc3");
  endtask

  task automatic test_reset_mid();
    int n_done;
    @(negedge CLK);
    bus.COMPUTE = 1'b1; bus.OPERATION = 3'd0; bus.ACC_SEL = 2'd1; bus.CALC_DATA = 10'd7;
    @(negedge CLK);
    bus.COMPUTE = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_outputs("reset_mid");
    RESET = 1'b0;
    for (int i = 0; i < NA; i++) m_acc[i] = 0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin n_err++; $display("FAIL reset_mid_no_done: got %0d pulses, expected 0", n_done); end
    issue_and_check(0, 1, 3'd3, 1, 10'd0, "reset_mid_acc1");
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      issue_and_check(($urandom_range(0, 7) == 0), 1'b1, 3'($urandom_range(0, 7)),
                      int'($urandom_range(0, NA-1)), DW'($urandom), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_clear_priority();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_acc_calculator.md
Name: multi_acc_calculator

Overview:
Parametrised multi-accumulator calculator for the Lab 4 datapath family. It provides NUM_ACC independent accumulators and an 8-code operation set: add, subtract, bitwise logic, load and reserved. All arithmetic uses one shared ripple full adder. Each command returns carry/borrow, overflow and zero flags through the same DONE / RESULT_READY handshake the calculator front-end already uses.

Parameters:
DATA_WIDTH, 10, width of CALC_DATA operand
RESULT_WIDTH, 18, width of each accumulator and RESULT_DATA; must be >= DATA_WIDTH
NUM_ACC, 4, number of accumulators; power of two, >= 2
ACC_SEL_WIDTH, 2, log2(NUM_ACC)
SIGN_EXTEND, 0, 0 = zero-extend CALC_DATA to RESULT_WIDTH; 1 = sign-extend

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
CLEAR  input  1  clear the selected accumulator; sampled in IDLE only
COMPUTE  input  1  execute OPERATION; sampled in IDLE only
OPERATION  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LOAD, 110/111 reserved
ACC_SEL  input  ACC_SEL_WIDTH  target accumulator index
CALC_DATA  input  DATA_WIDTH  operand
BUSY  output  1  high while a command is in flight
DONE  output  1  one-cycle completion pulse
RESULT_READY  output  1  level; result valid
RESULT_SEL  output  ACC_SEL_WIDTH  accumulator index of the last command
RESULT_DATA  output  RESULT_WIDTH  contents of acc[RESULT_SEL]; combinational mux
CARRY  output  1  ADD carry-out; SUB borrow (1 when operand > acc, unsigned)
OVERFLOW  output  1  two's-complement overflow of ADD/SUB
ZERO  output  1  result == 0

Behaviour:
- Reset: all accumulators 0. BUSY, DONE, RESULT_READY, CARRY and OVERFLOW are 0. RESULT_SEL = 0, ZERO = 1, state = IDLE.
- RESET has priority over everything. If RESET is asserted mid-command, the pending accumulator write is abandoned and no DONE is produced.
- States are IDLE, SETUP, EXEC, CLR and FIN.
- IDLE:
  - DONE = 0 and BUSY = 0.
  - CLEAR has priority over COMPUTE when both are high on the same edge.
  - On CLEAR: latch ACC_SEL into RESULT_SEL, set RESULT_READY = 0 and BUSY = 1, go to CLR.
  - On COMPUTE: latch ACC_SEL, OPERATION and the extended operand; set RESULT_READY = 0 and BUSY = 1, go to SETUP.
- SETUP: form the adder inputs.
  - ADD: B = ext, CIN = 0.
  - SUB: B = ~ext, CIN = 1.
  - Go to EXEC.
- EXEC: write acc[sel] and the flags, then go to FIN.
  - ADD/SUB: acc = adder result.
  - ADD: CARRY = cout. SUB: CARRY = ~cout.
  - OVERFLOW = (A.msb == B.msb) && (RES.msb != A.msb), where B is the post-inversion operand.
  - AND/OR/XOR/LOAD: acc = acc op ext (LOAD: acc = ext). CARRY = 0, OVERFLOW = 0.
  - Reserved codes: acc unchanged, CARRY = 0, OVERFLOW = 0.
  - ZERO reflects the written value in every case.
- CLR: acc[sel] = 0, CARRY = 0, OVERFLOW = 0, ZERO = 1. Go to FIN.
- FIN: DONE = 1 and RESULT_READY = 1 for this cycle; BUSY = 0 on the next edge; return to IDLE. RESULT_READY holds until the next accepted command.
- Latency: for a COMPUTE accepted on edge N, DONE is high in the cycle after edge N+3. For CLEAR, DONE is high after edge N+2.
- Commands arriving while BUSY = 1 are ignored and not queued.
- Non-selected accumulators are never modified.
- All arithmetic is modulo 2^RESULT_WIDTH unless the saturation option below is compiled in.

Optional Feature:
Macro: CALC_SATURATE_EN
- Defined: ADD/SUB results are clamped on out-of-range results.
  - SIGN_EXTEND = 1: clamp to signed max 0x1FFFF or signed min 0x20000 (18-bit) when OVERFLOW = 1.
  - SIGN_EXTEND = 0: clamp to all-ones on ADD carry, or to 0 on SUB borrow.
  - CARRY and OVERFLOW still report the raw, unclamped event. ZERO reflects the stored value.
- Undefined: results wrap; no clamp logic is synthesised.

Test Plan:
- Reset; ADD 100 to acc0, then ADD 23 to acc0 -> RESULT_DATA = 123. DONE pulses exactly 4 cycles after each COMPUTE edge. acc1..acc3 read back 0.
- SUB 5 from acc1 = 0 -> 0x3FFFB, CARRY = 1, ZERO = 0. With CALC_SATURATE_EN -> 0x00000, CARRY = 1, ZERO = 1.
- acc2: LOAD 0x3AA, XOR 0x0FF -> 0x355, AND 0x00F -> 0x005. Then SUB 5 -> 0, ZERO = 1, CARRY = 0.
- acc3: SUB 1 -> 0x3FFFF, then ADD 1 -> 0, CARRY = 1, ZERO = 1, OVERFLOW = 0 (no saturation build).
- CLEAR and COMPUTE on the same edge with acc0 = 123 -> CLEAR wins: acc0 = 0, DONE 3 cycles later, no arithmetic executed. A COMPUTE pulse while BUSY = 1 is ignored: acc unchanged and only one DONE is produced.
- RESET asserted while in EXEC for ADD 7 on acc1 -> acc1 = 0, DONE never pulses, and all outputs show their reset values on the next edge.
